// File: rtl/operand_fwd_if.sv
// Operand-select request/result bundle between decode and the forwarding mux.
// The design drives only the registered result fields.
interface operand_fwd_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] imm_data;
  logic              imm_sel;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_fwd;

  modport master (
    output wr_en, wr_addr, wr_data, rs_addr, rf_data, imm_data, imm_sel,
           in_valid, stall, flush,
    input  out_data, out_valid, out_fwd
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs_addr, rf_data, imm_data, imm_sel,
           in_valid, stall, flush,
    output out_data, out_valid, out_fwd
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// Registered ALU operand select: immediate, same-cycle bypass, youngest
// matching writeback from a DEPTH-entry history, else register-file data.
module operand_fwd_mux #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DEPTH    = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  operand_fwd_if.slave bus
);

  logic [DEPTH-1:0]  hist_v;
  logic [ADDR_W-1:0] hist_addr [DEPTH];
  logic [DATA_W-1:0] hist_data [DEPTH];

  logic              wr_q_c;
  logic              rs_zero_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              sel_fwd_c;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              fwd_q;

  // A write to a hardwired r0 is discarded, so it can neither bypass nor be recorded.
  assign wr_q_c    = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
  assign rs_zero_c = ZERO_REG && (bus.rs_addr == '0);

  // Walk oldest to youngest so the youngest hit overrides; bypass then immediate on top.
  always_comb begin
    sel_data_c = bus.rf_data;
    sel_fwd_c  = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (hist_v[k] && (hist_addr[k] == bus.rs_addr)) begin
        sel_data_c = hist_data[k];
        sel_fwd_c  = 1'b1;
      end
    end
    if (wr_q_c && (bus.wr_addr == bus.rs_addr)) begin
      sel_data_c = bus.wr_data;
      sel_fwd_c  = 1'b1;
    end
    if (rs_zero_c) begin
      sel_data_c = bus.rf_data;
      sel_fwd_c  = 1'b0;
    end
    if (bus.imm_sel) begin
      sel_data_c = bus.imm_data;
      sel_fwd_c  = 1'b0;
    end
  end

  // Writeback history: architectural, so it ignores stall and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        hist_addr[k] <= '0;
        hist_data[k] <= '0;
      end
    end else if (wr_q_c) begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        hist_v[k]    <= hist_v[k-1];
        hist_addr[k] <= hist_addr[k-1];
        hist_data[k] <= hist_data[k-1];
      end
      hist_v[0]    <= 1'b1;
      hist_addr[0] <= bus.wr_addr;
      hist_data[0] <= bus.wr_data;
    end
  end

  // Output stage: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fwd_q   <= 1'b0;
    end else if (bus.flush) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fwd_q   <= 1'b0;
    end else if (!bus.stall) begin
      data_q  <= sel_data_c;
      valid_q <= bus.in_valid;
      fwd_q   <= sel_fwd_c;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_fwd   = fwd_q;

endmodule
